// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op selects, R-type funct codes,
// forwarding selects and the multiply/divide op and state types.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // Values match funct[1:0] of mult/multu/div/divu.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, sign-corrected into HI/LO on the last step.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output md_state_t       state
);

  localparam int CW = $clog2(MD_CYCLES);

  md_state_t       state_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc_hi, acc_lo, b_mag, dividend;
  logic            is_div, neg_main, neg_rem, div_zero;
  logic            signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag_in;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [XLEN-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [2*XLEN-1:0] prod;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = signed_op & a[XLEN-1];
  assign b_neg     = signed_op & b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag_in  = b_neg ? -b : b;
  assign busy      = (state == MD_BUSY);

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (count == '0) state_next = MD_IDLE;
    endcase
  end

  // Multiply: acc_lo holds the multiplier and shifts right into the product.
  // Divide: acc_lo holds the dividend and shifts left as quotient bits enter.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, b_mag};
    step_hi   = mul_sum[XLEN:1];
    step_lo   = {mul_sum[0], acc_lo[XLEN-1:1]};
    if (is_div) begin
      if (!div_trial[XLEN]) begin
        step_hi = div_trial[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod   = neg_main ? -{step_hi, step_lo} : {step_hi, step_lo};
    fin_hi = prod[2*XLEN-1:XLEN];
    fin_lo = prod[XLEN-1:0];
    if (is_div) begin
      if (div_zero) begin
        fin_hi = dividend;
        fin_lo = '1;
      end else begin
        fin_hi = neg_rem  ? -step_hi : step_hi;
        fin_lo = neg_main ? -step_lo : step_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_mag    <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (state == MD_IDLE && start) begin
      count    <= CW'(MD_CYCLES - 1);
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      b_mag    <= b_mag_in;
      dividend <= a;
      is_div   <= (op == MD_DIV) || (op == MD_DIVU);
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (b == '0);
    end else if (state == MD_BUSY) begin
      count  <= count - CW'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (count == '0) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, EX/MEM register and HI/LO stall logic.
// Multiply/divide support (HI/LO, mfhi/mflo, mult*/div*) is built only when MULDIV_EN is defined.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_pc,
  input  logic [XLEN-1:0] id_read_data1,
  input  logic [XLEN-1:0] id_read_data2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [5:0]      id_funct,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_dst,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] wb_result,
  output logic            stall_o,
  output logic            exmem_valid,
  output logic [31:0]     exmem_pc,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_write_data,
  output logic [4:0]      exmem_write_reg,
  output logic            exmem_reg_write,
  output logic            exmem_mem_read,
  output logic            exmem_mem_write,
  output logic            exmem_mem_to_reg,
  output logic            md_busy
);

  if (MD_CYCLES != XLEN) begin : g_bad_cfg
    $error("ex_stage: MD_CYCLES must equal XLEN");
  end

  logic [XLEN-1:0] op_a, rt_val, op_b, alu_result;
  logic            alu_write, bubble;

`ifdef MULDIV_EN
  logic            md_req, md_dep, md_start, md_busy_w;
  logic [XLEN-1:0] hi, lo;
  md_state_t       md_state;
`endif

  always_comb begin
    case (forward_a)
      FWD_MEM: op_a = exmem_alu_result;
      FWD_WB:  op_a = wb_result;
      default: op_a = id_read_data1;
    endcase
    case (forward_b)
      FWD_MEM: rt_val = exmem_alu_result;
      FWD_WB:  rt_val = wb_result;
      default: rt_val = id_read_data2;
    endcase
    op_b = id_alu_src ? id_imm : rt_val;
  end

  always_comb begin
    alu_result = '0;
    alu_write  = id_reg_write;
`ifdef MULDIV_EN
    md_req = 1'b0;
    md_dep = 1'b0;
`endif
    case (id_alu_op)
      ALUOP_ADD: alu_result = op_a + op_b;
      ALUOP_SUB: alu_result = op_a - op_b;
      ALUOP_OR:  alu_result = op_a | op_b;
      ALUOP_FUNCT: begin
        case (id_funct)
          F_ADD, F_ADDU: alu_result = op_a + op_b;
          F_SUB, F_SUBU: alu_result = op_a - op_b;
          F_AND:  alu_result = op_a & op_b;
          F_OR:   alu_result = op_a | op_b;
          F_XOR:  alu_result = op_a ^ op_b;
          F_NOR:  alu_result = ~(op_a | op_b);
          F_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          F_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
`ifdef MULDIV_EN
          F_MFHI: begin
            alu_result = hi;
            md_dep     = 1'b1;
          end
          F_MFLO: begin
            alu_result = lo;
            md_dep     = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            alu_write = 1'b0;
            md_dep    = 1'b1;
            md_req    = 1'b1;
          end
`else
          F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU: alu_write = 1'b0;
`endif
          default: alu_write = 1'b0;
        endcase
      end
    endcase
  end

`ifdef MULDIV_EN
  // HI/LO readers and new mult/div wait while an operation is in flight.
  assign stall_o  = id_valid & md_dep & (md_state == MD_BUSY);
  assign md_start = id_valid & md_req & ~stall_o;
  assign md_busy  = md_busy_w;

  muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op_t'(id_funct[1:0])),
    .a     (op_a),
    .b     (rt_val),
    .busy  (md_busy_w),
    .hi    (hi),
    .lo    (lo),
    .state (md_state)
  );
`else
  assign stall_o = 1'b0;
  assign md_busy = 1'b0;
`endif

  // Bubbles and stalled slots carry no control so nothing downstream commits them.
  assign bubble = ~id_valid | stall_o;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      exmem_valid      <= 1'b0;
      exmem_pc         <= '0;
      exmem_alu_result <= '0;
      exmem_write_data <= '0;
      exmem_write_reg  <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
    end else begin
      exmem_valid      <= 1'b1;
      exmem_pc         <= id_pc;
      exmem_alu_result <= alu_result;
      exmem_write_data <= rt_val;
      exmem_write_reg  <= id_reg_dst ? id_rd : id_rt;
      exmem_reg_write  <= alu_write;
      exmem_mem_read   <= id_mem_read;
      exmem_mem_write  <= id_mem_write;
      exmem_mem_to_reg <= id_mem_to_reg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an EX/MEM scoreboard; mult/div scenarios
// are exercised when MULDIV_EN is defined, otherwise their "other" decoding is checked.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int EW = 106;
  localparam logic [EW-1:0] M_ALL    = {EW{1'b1}};
  localparam logic [EW-1:0] M_NO_RES = ~{{(EW-64){1'b0}}, 32'hFFFFFFFF, 32'h0};

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_read_data1, id_read_data2, id_imm;
  logic [4:0]  id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] wb_result;
  logic        stall_o, exmem_valid;
  logic [31:0] exmem_pc, exmem_alu_result, exmem_write_data;
  logic [4:0]  exmem_write_reg;
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, md_busy;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mask_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr;
  logic [5:0] fn_tab [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h00};

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .forward_a(forward_a), .forward_b(forward_b), .wb_result(wb_result),
    .stall_o(stall_o), .exmem_valid(exmem_valid), .exmem_pc(exmem_pc),
    .exmem_alu_result(exmem_alu_result), .exmem_write_data(exmem_write_data),
    .exmem_write_reg(exmem_write_reg), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .exmem_mem_to_reg(exmem_mem_to_reg), .md_busy(md_busy)
  );

  function automatic logic [EW-1:0] pack(input logic v, rw, mr, mw, mtr, input logic [4:0] wr,
                                         input logic [31:0] wd, res, pc);
    return {v, rw, mr, mw, mtr, wr, wd, res, pc};
  endfunction

  function automatic logic [32:0] alu_ref(input logic [5:0] fn, input logic [31:0] a, b);
    case (fn)
      6'h20, 6'h21: return {1'b1, a + b};
      6'h22, 6'h23: return {1'b1, a - b};
      6'h24: return {1'b1, a & b};
      6'h25: return {1'b1, a | b};
      6'h26: return {1'b1, a ^ b};
      6'h27: return {1'b1, ~(a | b)};
      6'h2A: return {1'b1, 31'd0, $signed(a) < $signed(b)};
      6'h2B: return {1'b1, 31'd0, a < b};
      default: return 33'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [EW-1:0] e, input logic [EW-1:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
  endtask

  task automatic step(input string tag);
    logic [EW-1:0] o, e, m;
    @(posedge clk);
    #1;
    o = pack(exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg,
             exmem_write_reg, exmem_write_data, exmem_alu_result, exmem_pc);
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    check(tag, o & m, e & m);
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, b);
    id_valid = 1'b1;      id_pc = pc_ctr;       pc_ctr = pc_ctr + 32'd4;
    id_alu_op = op;       id_funct = fn;
    id_read_data1 = a;    id_read_data2 = b;    id_imm = 32'h0;
    id_alu_src = 1'b0;    id_reg_dst = 1'b1;    id_rt = 5'd2;  id_rd = 5'd3;
    id_reg_write = 1'b1;  id_mem_read = 1'b0;   id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    forward_a = FWD_RF;   forward_b = FWD_RF;
  endtask

  task automatic idle_step(input string tag);
    id_valid = 1'b0;
    push('0, M_ALL);
    step(tag);
  endtask

  task automatic md_issue(input logic [5:0] fn, input logic [31:0] a, b, input string tag);
    instr(ALUOP_FUNCT, fn, a, b);
    push(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, b, 32'h0, id_pc), M_NO_RES);
    step(tag);
  endtask

  // Issues mfhi/mflo, absorbing stalled cycles as bubbles, then checks the result.
  task automatic dep_issue(input logic [5:0] fn, input logic [31:0] exp_res,
                           input int exp_stalls, input string tag);
    int stalls;
    stalls = 0;
    instr(ALUOP_FUNCT, fn, 32'h0, 32'h0);
    id_rd = 5'd8;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
      push('0, M_ALL);
      step({tag, "_bubble"});
    end
    check({tag, "_stalls"}, EW'(stalls), EW'(exp_stalls));
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0, exp_res, id_pc), M_ALL);
    step(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [32:0] r;
    pc_ctr = 32'h100;
    wb_result = 32'h0;
    rst = 1'b1;
    instr(ALUOP_FUNCT, F_ADD, 32'd1, 32'd2);
    for (int i = 0; i < 2; i++) begin
      push('0, M_ALL);
      step("reset_exmem");
      check("reset_stall", EW'(stall_o), '0);
      check("reset_busy", EW'(md_busy), '0);
    end
    rst = 1'b0;

    instr(ALUOP_ADD, 6'h0, 32'd2, 32'h11);
    id_alu_src = 1'b1; id_imm = 32'd3; id_reg_dst = 1'b0;
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h11, 32'd5, id_pc), M_ALL);
    step("first_result");

    instr(ALUOP_FUNCT, F_ADD, 32'hDEAD, 32'd7);
    forward_a = FWD_MEM;
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd7, 32'd12, id_pc), M_ALL);
    step("fwd_mem_add");

    instr(ALUOP_ADD, 6'h0, 32'h1000, 32'h55);
    id_alu_src = 1'b1; id_imm = 32'd4; id_reg_dst = 1'b0; id_reg_write = 1'b0;
    id_mem_write = 1'b1; forward_b = FWD_WB; wb_result = 32'd9;
    push(pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'd9, 32'h1004, id_pc), M_ALL);
    step("sw_fwd_wb");

    instr(ALUOP_FUNCT, F_SUB, 32'd50, 32'd8);
    forward_a = 2'b11; wb_result = 32'd999;
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd8, 32'd42, id_pc), M_ALL);
    step("fwd_11_is_rf");

    instr(ALUOP_ADD, 6'h3F, 32'h2000, 32'h0);
    id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC; id_reg_dst = 1'b0;
    id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    push(pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h1FFC, id_pc), M_ALL);
    step("lw_neg_imm");

    instr(ALUOP_SUB, 6'h3F, 32'd10, 32'd3);
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd3, 32'd7, id_pc), M_ALL);
    step("aluop_sub");
    instr(ALUOP_OR, 6'h3F, 32'hF0, 32'h0F);
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0F, 32'hFF, id_pc), M_ALL);
    step("aluop_or");

    instr(ALUOP_FUNCT, F_SLT, 32'h80000000, 32'd1);
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd1, 32'd1, id_pc), M_ALL);
    step("slt_signed_min");
    instr(ALUOP_FUNCT, F_SLTU, 32'h80000000, 32'd1);
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd1, 32'd0, id_pc), M_ALL);
    step("sltu_signed_min");

    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = (k % 3 == 0) ? a : $urandom;
      instr(ALUOP_FUNCT, fn_tab[k % 12], a, b);
      r = alu_ref(fn_tab[k % 12], a, b);
      push(pack(1'b1, r[32], 1'b0, 1'b0, 1'b0, 5'd3, b, r[31:0], id_pc), M_ALL);
      step("alu_funct_table");
    end

    idle_step("bubble_in");

`ifdef MULDIV_EN
    md_issue(F_MULTU, 32'hFFFFFFFF, 32'd2, "multu_issue");
    check("multu_busy", EW'(md_busy), EW'(1));
    dep_issue(F_MFHI, 32'd1, 32, "mfhi_multu");
    dep_issue(F_MFLO, 32'hFFFFFFFE, 0, "mflo_multu");
    check("idle_busy", EW'(md_busy), '0);

    md_issue(F_DIV, 32'hFFFFFFF9, 32'd2, "div_issue");
    dep_issue(F_MFLO, 32'hFFFFFFFD, 32, "div_lo");
    dep_issue(F_MFHI, 32'hFFFFFFFF, 0, "div_hi");

    md_issue(F_DIVU, 32'd10, 32'd0, "divz_issue");
    dep_issue(F_MFLO, 32'hFFFFFFFF, 32, "divz_lo");
    dep_issue(F_MFHI, 32'd10, 0, "divz_hi");

    md_issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, "divovf_issue");
    dep_issue(F_MFLO, 32'h80000000, 32, "divovf_lo");
    dep_issue(F_MFHI, 32'h0, 0, "divovf_hi");

    md_issue(F_MULT, 32'hFFFFFFFD, 32'd5, "mult_issue");
    dep_issue(F_MFHI, 32'hFFFFFFFF, 32, "mult_hi");
    dep_issue(F_MFLO, 32'hFFFFFFF1, 0, "mult_lo");

    md_issue(F_MULTU, 32'd7, 32'd6, "overlap_mult");
    instr(ALUOP_FUNCT, F_ADD, 32'd100, 32'd23);
    @(negedge clk);
    check("overlap_no_stall", EW'(stall_o), '0);
    check("overlap_busy", EW'(md_busy), EW'(1));
    push(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'd23, 32'd123, id_pc), M_ALL);
    step("overlap_add");
    dep_issue(F_MFLO, 32'd42, 31, "overlap_lo");

    md_issue(F_MULTU, 32'd3, 32'd4, "abort_mult");
    for (int i = 0; i < 10; i++) idle_step("abort_iter");
    rst = 1'b1;
    push('0, M_ALL);
    step("abort_reset");
    check("abort_busy", EW'(md_busy), '0);
    rst = 1'b0;
    dep_issue(F_MFHI, 32'h0, 0, "abort_hi");
    dep_issue(F_MFLO, 32'h0, 0, "abort_lo");
`else
    instr(ALUOP_FUNCT, F_MULT, 32'd3, 32'd4);
    @(negedge clk);
    check("nomd_mult_stall", EW'(stall_o), '0);
    push(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd4, 32'd0, id_pc), M_ALL);
    step("nomd_mult");
    check("nomd_busy", EW'(md_busy), '0);
    instr(ALUOP_FUNCT, F_MFHI, 32'd5, 32'd6);
    @(negedge clk);
    check("nomd_mfhi_stall", EW'(stall_o), '0);
    push(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd6, 32'd0, id_pc), M_ALL);
    step("nomd_mfhi");
`endif

    idle_step("final_bubble");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Applies forwarding muxes and ALU-source selection, then computes the ALU result.
- Runs an iterative multiply/divide unit that writes HI/LO.
- Registers all results into the EX/MEM pipeline register and raises a stall to upstream stages while a HI/LO-dependent instruction must wait.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iteration count of the multiply/divide FSM. Must equal XLEN.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- id_pc  in  32  PC of the instruction.
- id_read_data1, id_read_data2  in  32 each  register file operands.
- id_imm  in  32  sign-extended immediate.
- id_rt, id_rd  in  5 each  destination candidates.
- id_funct  in  6  R-type function code.
- id_alu_op  in  2  00 add, 01 sub, 10 use funct, 11 or.
- id_alu_src  in  1  1 = operand B is id_imm.
- id_reg_dst  in  1  1 = destination is rd, 0 = rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control passed downstream.
- forward_a, forward_b  in  2 each  00 register file, 10 exmem_alu_result, 01 wb_result, 11 treated as 00.
- wb_result  in  32  WB-stage writeback value.
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle.
- exmem_valid  out  1  EX/MEM entry valid.
- exmem_pc  out  32  PC passed downstream.
- exmem_alu_result  out  32  registered ALU or HI/LO result; also the forwarding source.
- exmem_write_data  out  32  forwarded operand B, used as store data.
- exmem_write_reg  out  5  destination register.
- exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg  out  1 each  registered control.
- md_busy  out  1  multiply/divide FSM running.

Behaviour:
- Reset: all exmem_* outputs are 0, HI=LO=0, FSM IDLE, md_busy=0, stall_o=0. Reset mid-iteration aborts the operation and leaves HI/LO=0.
- Latency: one cycle. EX/MEM updates on every edge when rst=0.
- ALU for alu_op=10, by funct:
  - 0x20/0x21 add (wraps, no overflow trap); 0x22/0x23 sub.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x10 mfhi, 0x12 mflo (result = HI / LO).
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu: issue to the FSM; EX/MEM gets reg_write=0.
  - Any other funct: result 0, reg_write forced to 0.
- Operands: operand A = forwarded rs. Operand B = id_imm if id_alu_src=1, else forwarded rt. exmem_write_data is always forwarded rt.
- Stall rule: stall_o=1 when id_valid and md_busy and funct is in {mfhi, mflo, mult*, div*} with alu_op=10.
  - While stalled, EX/MEM captures a bubble: valid=0 and all control bits 0.
  - Independent instructions proceed while md_busy=1.
- FSM states IDLE -> BUSY -> IDLE.
  - IDLE to BUSY: on an accepted mult/div. Operands are latched, and signed ops take magnitudes.
  - BUSY: counter runs MD_CYCLES-1 down to 0, one shift-add or restoring-subtract step per cycle.
  - At count 0: HI/LO are written (sign-corrected) and the FSM returns to IDLE. md_busy falls on the next cycle.
  - A stalled mfhi is released that cycle and reads the new HI/LO.
  - Total: a dependent mfhi issued right after mult stalls exactly MD_CYCLES cycles.
- Multiply: {HI,LO} = 64-bit product.
- Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend; takes the full MD_CYCLES.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.

Optional Feature:
- MULDIV_EN defined: HI/LO, the FSM, and the mult/div/mfhi/mflo functs are present as above.
- MULDIV_EN undefined: those functs are decoded as "other" (result 0, no write). md_busy and stall_o are tied to 0, and no HI/LO registers exist.

Decomposition:
- Package ex_pkg holds:
  - ALU op encodings (ALUOP_ADD/SUB/FUNCT/OR).
  - funct localparams.
  - forward-select encodings (FWD_RF/FWD_MEM/FWD_WB).
- One sub-module: muldiv_unit. It contains the FSM, counter, HI/LO and the sign correction, with a start/op/busy/hi/lo interface.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 -> all exmem_* 0, stall_o=0; release -> first result one cycle later.
- Forwarding: add with forward_a=10, exmem_alu_result=5, rt=7 -> 12; forward_b=01 with wb_result=9 and sw -> exmem_write_data=9.
- Multiply: multu 0xFFFFFFFF*2, then mfhi -> stall_o high 32 cycles, EX/MEM bubbles, then mfhi result 1; mflo gives 0xFFFFFFFE.
- Signed divide: div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divide by zero, 10/0 -> LO=0xFFFFFFFF, HI=10.
- Overlap: mult followed by independent add -> add completes with no stall while md_busy=1.
- Abort: rst at iteration 10 -> md_busy=0 next cycle, HI=LO=0, and a following mfhi returns 0 without stall.
